// File: rtl/sound_player.sv
// Sound-effect sequencer: plays one of four short note sequences as a square
// wave on audio_out, triggered by a rising edge on playsound.
module sound_player #(
  parameter int unsigned NOTE_LEN   = 3000000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] current_sound
);

  localparam int unsigned NCW = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam logic [NCW-1:0] NOTE_LAST = NCW'(NOTE_LEN - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t         state;
  logic           play_q;
  logic           armed;
  logic [1:0]     note_idx;
  logic [NCW-1:0] note_cnt;
  logic [15:0]    tone_cnt;
  logic           phase;

  logic [15:0]    raw;
  logic [15:0]    h;
  logic [1:0]     last_idx;
  logic           tone_hit;
  logic           note_end;
  logic           trig;
  logic           phase_next;

  function automatic logic [15:0] half_period(input logic [15:0] tv);
    logic [15:0] hp;
    hp = tv >> TONE_SHIFT;
    if (tv != 16'd0 && hp == 16'd0) hp = 16'd1;
    return hp;
  endfunction

  always_comb begin
    raw      = '0;
    last_idx = '0;
    case (current_sound)
      2'd0: begin
        last_idx = 2'd0;
        raw      = 16'd5733;
      end
      2'd1: begin
        last_idx = 2'd2;
        case (note_idx)
          2'd0:    raw = 16'd11467;
          2'd1:    raw = 16'd9101;
          default: raw = 16'd7653;
        endcase
      end
      2'd2: begin
        last_idx = 2'd3;
        case (note_idx)
          2'd0:    raw = 16'd15306;
          2'd1:    raw = 16'd0;
          2'd2:    raw = 16'd22933;
          default: raw = 16'd30612;
        endcase
      end
      default: begin
        last_idx = 2'd3;
        case (note_idx)
          2'd0:    raw = 16'd11467;
          2'd1:    raw = 16'd9101;
          2'd2:    raw = 16'd7653;
          default: raw = 16'd5733;
        endcase
      end
    endcase
  end

  // The original edge detect fired on the first clock after reset if playsound
  // was already high; armed blocks that until playsound has been seen low.
  always_comb begin
    h          = half_period(raw);
    tone_hit   = (h != 16'd0) && (tone_cnt == h - 16'd1);
    note_end   = (note_cnt == NOTE_LAST);
    trig       = playsound && !play_q && armed;
    phase_next = tone_hit ? ~phase : phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      play_q        <= 1'b0;
      armed         <= 1'b0;
      note_idx      <= '0;
      note_cnt      <= '0;
      tone_cnt      <= '0;
      phase         <= 1'b0;
      busy          <= 1'b0;
      current_sound <= '0;
      audio_out     <= 1'b0;
    end else begin
      play_q <= playsound;
      if (!playsound) armed <= 1'b1;
      if (trig) begin
        state         <= PLAY;
        busy          <= 1'b1;
        current_sound <= soundselector;
        note_idx      <= '0;
        note_cnt      <= '0;
        tone_cnt      <= '0;
        phase         <= 1'b0;
        audio_out     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy      <= 1'b0;
            phase     <= 1'b0;
            audio_out <= 1'b0;
          end
          PLAY: begin
            if (note_end) begin
              note_cnt  <= '0;
              tone_cnt  <= '0;
              phase     <= 1'b0;
              audio_out <= 1'b0;
              if (note_idx == last_idx) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                note_idx <= note_idx + 2'd1;
              end
            end else begin
              note_cnt  <= note_cnt + 1'b1;
              phase     <= phase_next;
              audio_out <= phase_next & ~mute;
              if (tone_hit || h == 16'd0) tone_cnt <= '0;
              else                        tone_cnt <= tone_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
